// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with flush bubbles, stall hold and a saturating bubble counter; optional HAZARD_DETECT_EN adds load-use bubbles.
// Latency: 1 cycle ID->EX; stall_req_o is the only combinational output.
// Backpressure: stall_i holds every register; flush_i (or a load-use bubble) writes a zeroed slot instead.
module id_ex_pipe_reg #(
  parameter int         XLEN        = 32,
  parameter int         RAW         = 5,
  parameter logic [1:0] RESMUX_LOAD = 2'b01,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_alusrc,
  input  logic             id_memwrite,
  input  logic             id_a2src,
  input  logic             id_regwrite,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic [1:0]       id_resmux,
  input  logic [1:0]       id_be,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic [RAW-1:0]   id_rd,
  output logic             ex_valid_o,
  output logic [3:0]       ex_alu_ctrl,
  output logic             ex_alusrc,
  output logic             ex_memwrite,
  output logic             ex_a2src,
  output logic             ex_regwrite,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [1:0]       ex_resmux,
  output logic [1:0]       ex_be,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RAW-1:0]   ex_rs1,
  output logic [RAW-1:0]   ex_rs2,
  output logic [RAW-1:0]   ex_rd,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic             stall_req_o
);

  typedef struct packed {
    logic            valid;
    logic [3:0]      alu_ctrl;
    logic            alusrc;
    logic            memwrite;
    logic            a2src;
    logic            regwrite;
    logic            branch;
    logic            jump;
    logic [1:0]      resmux;
    logic [1:0]      be;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
  } slot_t;

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  slot_t            id_d;
  slot_t            ex_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic             bubble;

  // An invalid slot keeps its data for visibility but can never commit state.
  always_comb begin
    id_d          = '0;
    id_d.valid    = id_valid_i;
    id_d.alu_ctrl = id_alu_ctrl;
    id_d.alusrc   = id_alusrc;
    id_d.memwrite = id_memwrite & id_valid_i;
    id_d.a2src    = id_a2src;
    id_d.regwrite = id_regwrite & id_valid_i;
    id_d.branch   = id_branch & id_valid_i;
    id_d.jump     = id_jump & id_valid_i;
    id_d.resmux   = id_resmux;
    id_d.be       = id_be;
    id_d.pc       = id_pc;
    id_d.rs1_data = id_rs1_data;
    id_d.rs2_data = id_rs2_data;
    id_d.imm      = id_imm;
    id_d.rs1      = id_rs1;
    id_d.rs2      = id_rs2;
    id_d.rd       = id_rd;
  end

  assign load_use = HAZ_EN & ex_q.valid & (ex_q.resmux == RESMUX_LOAD) & ex_q.regwrite
                  & (ex_q.rd != '0) & id_valid_i
                  & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  assign stall_req_o = load_use & ~flush_i;
  assign bubble      = flush_i | (~stall_i & load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bubble) begin
      ex_q <= '0;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (!stall_i) begin
      ex_q <= id_d;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_alu_ctrl  = ex_q.alu_ctrl;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_a2src     = ex_q.a2src;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_resmux    = ex_q.resmux;
  assign ex_be        = ex_q.be;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a bench-side model predicts each EX slot and a one-deep
// scoreboard queue holds the prediction until the edge that should produce it.
module tb_id_ex_pipe_reg;

  localparam logic [1:0] RESMUX_LOAD = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic        alusrc;
    logic        memwrite;
    logic        a2src;
    logic        regwrite;
    logic        branch;
    logic        jump;
    logic [1:0]  resmux;
    logic [1:0]  be;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic [3:0]  id_alu_ctrl = '0;
  logic        id_alusrc = 1'b0, id_memwrite = 1'b0, id_a2src = 1'b0;
  logic        id_regwrite = 1'b0, id_branch = 1'b0, id_jump = 1'b0;
  logic [1:0]  id_resmux = '0, id_be = '0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic        ex_valid_o, ex_alusrc, ex_memwrite, ex_a2src, ex_regwrite, ex_branch, ex_jump;
  logic [3:0]  ex_alu_ctrl;
  logic [1:0]  ex_resmux, ex_be;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] bubble_cnt_o;
  logic        stall_req_o;

  int    errors = 0;
  int    checks = 0;
  slot_t model = '0;
  int    exp_cnt = 0;
  slot_t sb_q[$];

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_alu_ctrl(id_alu_ctrl), .id_alusrc(id_alusrc), .id_memwrite(id_memwrite),
    .id_a2src(id_a2src), .id_regwrite(id_regwrite), .id_branch(id_branch), .id_jump(id_jump),
    .id_resmux(id_resmux), .id_be(id_be), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid_o(ex_valid_o), .ex_alu_ctrl(ex_alu_ctrl), .ex_alusrc(ex_alusrc),
    .ex_memwrite(ex_memwrite), .ex_a2src(ex_a2src), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_resmux(ex_resmux), .ex_be(ex_be),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .bubble_cnt_o(bubble_cnt_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  function automatic slot_t observed();
    slot_t s;
    s = '{ex_valid_o, ex_alu_ctrl, ex_alusrc, ex_memwrite, ex_a2src, ex_regwrite, ex_branch,
          ex_jump, ex_resmux, ex_be, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd};
    return s;
  endfunction

  function automatic slot_t from_id();
    slot_t s;
    s = '{id_valid_i, id_alu_ctrl, id_alusrc, id_memwrite, id_a2src, id_regwrite, id_branch,
          id_jump, id_resmux, id_be, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd};
    if (!id_valid_i) begin
      s.regwrite = 1'b0;
      s.memwrite = 1'b0;
      s.branch   = 1'b0;
      s.jump     = 1'b0;
    end
    return s;
  endfunction

  task automatic check_slot(input string tag, input slot_t obs, input slot_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] alu, input logic rw, input logic [1:0] rm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid_i  = v;
    id_alu_ctrl = alu;
    id_regwrite = rw;
    id_resmux   = rm;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_alusrc   = 1'($urandom);
    id_a2src    = 1'($urandom);
    id_memwrite = 1'($urandom);
    id_branch   = 1'($urandom);
    id_jump     = 1'($urandom);
    id_be       = 2'($urandom);
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
  endtask

  // Predict, check stall_req_o before the edge, then compare the EX slot after it.
  task automatic cycle(input string tag);
    slot_t nxt;
    slot_t got;
    logic  lu;
    #1;
    lu = model.valid && (model.resmux == RESMUX_LOAD) && model.regwrite && (model.rd != 5'd0)
         && id_valid_i && ((model.rd == id_rs1) || (model.rd == id_rs2));
`ifndef HAZARD_DETECT_EN
    lu = 1'b0;
`endif
    check_val({tag, "_stall_req"}, 32'(stall_req_o), 32'(lu & ~flush_i));
    if (flush_i || (!stall_i && lu)) begin
      nxt = '0;
      if (exp_cnt < 65535) exp_cnt++;
    end else if (stall_i) begin
      nxt = model;
    end else begin
      nxt = from_id();
    end
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    got   = observed();
    model = sb_q.pop_front();
    check_slot(tag, got, model);
    check_val({tag, "_cnt"}, 32'(bubble_cnt_o), 32'(exp_cnt));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_slot("reset_slot", observed(), '0);
    check_val("reset_cnt", 32'(bubble_cnt_o), 32'd0);
    check_val("reset_stall_req", 32'(stall_req_o), 32'd0);
    rst = 1'b0;

    // Basic capture with one-cycle latency
    set_id(1'b1, 4'h3, 1'b1, 2'b00, 5'd1, 5'd2, 5'd3);
    id_imm = 32'h0000_0010;
    cycle("capture");
    check_val("capture_alu", 32'(ex_alu_ctrl), 32'h3);
    check_val("capture_imm", ex_imm, 32'h10);
    check_val("capture_valid", 32'(ex_valid_o), 32'd1);

    // Invalid slot must not commit
    set_id(1'b0, 4'h7, 1'b1, 2'b10, 5'd4, 5'd5, 5'd6);
    id_memwrite = 1'b1; id_branch = 1'b1; id_jump = 1'b1;
    cycle("invalid_slot");

    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 4'($urandom), 1'b1, 2'b00, 5'($urandom), 5'($urandom), 5'($urandom));
      cycle("stream");
    end

    // Stall three cycles while ID changes
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 4'($urandom), 1'b1, 2'b00, 5'd7, 5'd8, 5'd9);
      cycle("stall_hold");
    end
    stall_i = 1'b0;
    cycle("stall_release");

    // Flush wins over stall
    flush_i = 1'b1; stall_i = 1'b1;
    cycle("flush_and_stall");
    check_val("flush_valid", 32'(ex_valid_o), 32'd0);
    check_val("flush_regwrite", 32'(ex_regwrite), 32'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    // Mid-run async reset clears outputs before the next edge, including mid-stall
    set_id(1'b1, 4'h9, 1'b1, 2'b00, 5'd1, 5'd1, 5'd2);
    cycle("pre_reset");
    stall_i = 1'b1;
    rst = 1'b1;
    #2;
    check_slot("async_reset_slot", observed(), '0);
    check_val("async_reset_cnt", 32'(bubble_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; stall_i = 1'b0;
    model = '0; exp_cnt = 0;
    set_id(1'b1, 4'h5, 1'b1, 2'b00, 5'd1, 5'd2, 5'd10);
    cycle("post_reset_capture");

    // Load-use: load to x5 in EX, consumer reads x5
    set_id(1'b1, 4'h0, 1'b1, RESMUX_LOAD, 5'd1, 5'd2, 5'd5);
    cycle("load_enter");
    set_id(1'b1, 4'h1, 1'b1, 2'b00, 5'd5, 5'd3, 5'd6);
    cycle("load_use_bubble");
    cycle("load_use_recapture");
    // Load to x0 must never stall
    set_id(1'b1, 4'h0, 1'b1, RESMUX_LOAD, 5'd1, 5'd2, 5'd0);
    cycle("load_x0_enter");
    set_id(1'b1, 4'h2, 1'b1, 2'b00, 5'd0, 5'd0, 5'd7);
    cycle("load_x0_no_stall");
    // Load-use coinciding with flush: no upstream stall request
    set_id(1'b1, 4'h0, 1'b1, RESMUX_LOAD, 5'd1, 5'd2, 5'd12);
    cycle("load_flush_enter");
    set_id(1'b1, 4'h2, 1'b1, 2'b00, 5'd3, 5'd12, 5'd7);
    flush_i = 1'b1;
    cycle("load_use_flush");
    flush_i = 1'b0;

    // Counter saturation
    flush_i = 1'b1;
    for (int i = 0; i < 65539; i++) begin
      @(posedge clk);
      if (exp_cnt < 65535) exp_cnt++;
    end
    #1;
    model = '0;
    check_val("sat_cnt", 32'(bubble_cnt_o), 32'(exp_cnt));
    check_val("sat_ffff", 32'(bubble_cnt_o), 32'h0000_FFFF);
    cycle("sat_no_wrap");
    flush_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
